axi_rst_seq: RTL and testbench

//  Per-clock-domain reset sequencer feeding the clock/reset map of an AXI interconnect.

---
 rtl/axi_rst_seq.sv | 179 +++++++++++++++++
 tb/tb_axi_rst_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rst_seq.sv
// Per-domain AXI reset sequencer: synchronizes and merges reset requests, holds, then releases
// the interconnect first and the peripherals later. Optional status outputs: AXI_RST_SEQ_STATUS_EN.
module axi_rst_seq #(
  parameter int SYNC_STAGES  = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int IC_TO_PERIPH = 8
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       ext_reset_in,
  input  logic       aux_reset_in,
  input  logic       mb_debug_sys_rst,
  input  logic       dcm_locked,
  output logic       interconnect_aresetn,
  output logic       bus_struct_reset,
  output logic       peripheral_aresetn,
  output logic       peripheral_reset
`ifdef AXI_RST_SEQ_STATUS_EN
  ,
  output logic [3:0] rst_cause,
  output logic [7:0] rst_count
`endif
);

  localparam int CNT_MAX = (HOLD_CYCLES > IC_TO_PERIPH) ? HOLD_CYCLES : IC_TO_PERIPH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(IC_TO_PERIPH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REL_IC = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_ext_sync;
  logic [SYNC_STAGES-1:0] r_aux_sync;
  logic [SYNC_STAGES-1:0] r_dbg_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_ext_s;
  logic                   w_aux_s;
  logic                   w_dbg_s;
  logic                   w_locked_s;
  logic                   w_req;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_next_cnt;
  logic                   w_ic_rel;
  logic                   w_per_rel;
  logic                   r_ic_rel;
  logic                   r_per_rel;

  // Input synchronizers; on areset every chain holds its request-active value
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ext_sync  <= '1;
      r_aux_sync  <= '0;
      r_dbg_sync  <= '1;
      r_lock_sync <= '0;
    end else begin
      r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], ext_reset_in};
      r_aux_sync  <= {r_aux_sync[SYNC_STAGES-2:0], aux_reset_in};
      r_dbg_sync  <= {r_dbg_sync[SYNC_STAGES-2:0], mb_debug_sys_rst};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], dcm_locked};
    end
  end

  assign w_ext_s    = r_ext_sync[SYNC_STAGES-1];
  assign w_aux_s    = r_aux_sync[SYNC_STAGES-1];
  assign w_dbg_s    = r_dbg_sync[SYNC_STAGES-1];
  assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
  assign w_req      = w_ext_s | ~w_aux_s | w_dbg_s | ~w_locked_s;

  // State, counter and output flops; outputs follow the next state so they move on the transition edge
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_ic_rel  <= 1'b0;
      r_per_rel <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_ic_rel  <= w_ic_rel;
      r_per_rel <= w_per_rel;
    end
  end

  // Next-state and counter logic; any request sample restarts from ASSERT
  always_comb begin
    w_next_state = ST_ASSERT;
    w_next_cnt   = '0;
    case (r_state)
      ST_ASSERT: begin
        if (w_req) w_next_state = ST_ASSERT;
        else       w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_req) begin
          w_next_state = ST_ASSERT;
        end else if (r_cnt == HOLD_LAST) begin
          w_next_state = ST_REL_IC;
        end else begin
          w_next_state = ST_HOLD;
          w_next_cnt   = r_cnt + CNT_ONE;
        end
      end
      ST_REL_IC: begin
        if (w_req) begin
          w_next_state = ST_ASSERT;
        end else if (r_cnt == PERIPH_LAST) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_REL_IC;
          w_next_cnt   = r_cnt + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (w_req) w_next_state = ST_ASSERT;
        else       w_next_state = ST_RUN;
      end
      default: begin
        w_next_state = ST_ASSERT;
      end
    endcase
  end

  // Output decode from the next state
  always_comb begin
    w_ic_rel  = 1'b0;
    w_per_rel = 1'b0;
    case (w_next_state)
      ST_REL_IC: begin
        w_ic_rel  = 1'b1;
        w_per_rel = 1'b0;
      end
      ST_RUN: begin
        w_ic_rel  = 1'b1;
        w_per_rel = 1'b1;
      end
      default: begin
        w_ic_rel  = 1'b0;
        w_per_rel = 1'b0;
      end
    endcase
  end

  assign interconnect_aresetn = r_ic_rel;
  assign bus_struct_reset     = ~r_ic_rel;
  assign peripheral_aresetn   = r_per_rel;
  assign peripheral_reset     = ~r_per_rel;

`ifdef AXI_RST_SEQ_STATUS_EN
  logic       w_enter_assert;
  logic [3:0] r_rst_cause;
  logic [7:0] r_rst_count;

  assign w_enter_assert = (r_state != ST_ASSERT) && (w_next_state == ST_ASSERT);

  // Cause capture and saturating entry count, updated only on entry into ASSERT
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rst_cause <= 4'b0000;
      r_rst_count <= 8'h00;
    end else if (w_enter_assert) begin
      r_rst_cause <= {~w_locked_s, w_dbg_s, ~w_aux_s, w_ext_s};
      if (r_rst_count != 8'hFF) r_rst_count <= r_rst_count + 8'h01;
    end
  end

  assign rst_cause = r_rst_cause;
  assign rst_count = r_rst_count;
`endif

endmodule

// File: tb/tb_axi_rst_seq.sv
// Directed self-checking bench for axi_rst_seq with default parameters.
module tb_axi_rst_seq;

  logic aclk = 1'b0;
  logic areset;
  logic ext_reset_in;
  logic aux_reset_in;
  logic mb_debug_sys_rst;
  logic dcm_locked;
  logic interconnect_aresetn;
  logic bus_struct_reset;
  logic peripheral_aresetn;
  logic peripheral_reset;
`ifdef AXI_RST_SEQ_STATUS_EN
  logic [3:0] rst_cause;
  logic [7:0] rst_count;
`endif

  int errors = 0;
  int checks = 0;
  int pair_bad;
  logic ic_h [1:100];
  logic per_h[1:100];

  axi_rst_seq dut (
    .aclk                 (aclk),
    .areset               (areset),
    .ext_reset_in         (ext_reset_in),
    .aux_reset_in         (aux_reset_in),
    .mb_debug_sys_rst     (mb_debug_sys_rst),
    .dcm_locked           (dcm_locked),
    .interconnect_aresetn (interconnect_aresetn),
    .bus_struct_reset     (bus_struct_reset),
    .peripheral_aresetn   (peripheral_aresetn),
    .peripheral_reset     (peripheral_reset)
`ifdef AXI_RST_SEQ_STATUS_EN
    ,
    .rst_cause            (rst_cause),
    .rst_count            (rst_count)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic rec(input int e);
    tick();
    ic_h[e]  = interconnect_aresetn;
    per_h[e] = peripheral_aresetn;
    if (bus_struct_reset !== ~interconnect_aresetn || peripheral_reset !== ~peripheral_aresetn)
      pair_bad++;
  endtask

  function automatic int find_ic(input logic v, input int from, input int to);
    for (int e = from; e <= to; e++) if (ic_h[e] === v) return e;
    return -1;
  endfunction

  function automatic int find_per(input logic v, input int from, input int to);
    for (int e = from; e <= to; e++) if (per_h[e] === v) return e;
    return -1;
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    ext_reset_in = 1'b0; aux_reset_in = 1'b1; mb_debug_sys_rst = 1'b0; dcm_locked = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({interconnect_aresetn, bus_struct_reset, peripheral_aresetn, peripheral_reset} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0101",
               {interconnect_aresetn, bus_struct_reset, peripheral_aresetn, peripheral_reset});
    end
`ifdef AXI_RST_SEQ_STATUS_EN
    checks++;
    if (rst_cause !== 4'b0000 || rst_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_status: got cause=%b count=%0d expected 0000/0", rst_cause, rst_count);
    end
`endif
  endtask

  task automatic test_powerup(input string tag);
    int r;
    areset = 1'b0;
    pair_bad = 0;
    for (int e = 1; e <= 40; e++) rec(e);
    r = find_ic(1'b1, 1, 40);
    checks++;
    if (r !== 20) begin errors++; $display("FAIL %s_ic_rise: got edge %0d expected 20", tag, r); end
    r = find_per(1'b1, 1, 40);
    checks++;
    if (r !== 28) begin errors++; $display("FAIL %s_per_rise: got edge %0d expected 28", tag, r); end
    checks++;
    if (pair_bad !== 0) begin errors++; $display("FAIL %s_pairs: got %0d bad edges expected 0", tag, pair_bad); end
  endtask

  task automatic test_ext_pulse();
    int r;
    pair_bad = 0;
    ext_reset_in = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      rec(e);
      if (e == 1) ext_reset_in = 1'b0;
    end
    r = find_ic(1'b0, 1, 45);
    checks++;
    if (r !== 4) begin errors++; $display("FAIL ext_ic_fall: got edge %0d expected 4", r); end
    r = find_per(1'b0, 1, 45);
    checks++;
    if (r !== 4) begin errors++; $display("FAIL ext_per_fall: got edge %0d expected 4", r); end
    r = find_ic(1'b1, 5, 45);
    checks++;
    if (r !== 21) begin errors++; $display("FAIL ext_ic_rise: got edge %0d expected 21", r); end
    r = find_per(1'b1, 5, 45);
    checks++;
    if (r !== 29) begin errors++; $display("FAIL ext_per_rise: got edge %0d expected 29", r); end
    checks++;
    if (pair_bad !== 0) begin errors++; $display("FAIL ext_pairs: got %0d bad edges expected 0", pair_bad); end
  endtask

  task automatic test_hold_abort();
    int r;
    ext_reset_in = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      rec(e);
      if (e == 1)  ext_reset_in = 1'b0;
      if (e == 15) aux_reset_in = 1'b0;
      if (e == 17) aux_reset_in = 1'b1;
    end
    r = find_ic(1'b1, 5, 60);
    checks++;
    if (r !== 37) begin errors++; $display("FAIL hold_ic_rise: got edge %0d expected 37", r); end
    r = find_per(1'b1, 5, 60);
    checks++;
    if (r !== 45) begin errors++; $display("FAIL hold_per_rise: got edge %0d expected 45", r); end
  endtask

  task automatic test_relic_lockloss();
    int r;
    ext_reset_in = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      rec(e);
      if (e == 1)  ext_reset_in = 1'b0;
      if (e == 23) dcm_locked = 1'b0;
      if (e == 30) dcm_locked = 1'b1;
    end
    r = find_ic(1'b1, 5, 70);
    checks++;
    if (r !== 21) begin errors++; $display("FAIL lock_ic_rise1: got edge %0d expected 21", r); end
    r = find_ic(1'b0, 22, 70);
    checks++;
    if (r !== 27) begin errors++; $display("FAIL lock_ic_refall: got edge %0d expected 27", r); end
    r = find_ic(1'b1, 28, 70);
    checks++;
    if (r !== 50) begin errors++; $display("FAIL lock_ic_rise2: got edge %0d expected 50", r); end
    r = find_per(1'b1, 4, 70);
    checks++;
    if (r !== 58) begin errors++; $display("FAIL lock_per_rise: got edge %0d expected 58", r); end
  endtask

  task automatic test_async_mid_run();
    checks++;
    if ({interconnect_aresetn, bus_struct_reset, peripheral_aresetn, peripheral_reset} !== 4'b1010) begin
      errors++;
      $display("FAIL run_outputs: got %b expected 1010",
               {interconnect_aresetn, bus_struct_reset, peripheral_aresetn, peripheral_reset});
    end
    #3;
    areset = 1'b1;
    #1;
    checks++;
    if ({interconnect_aresetn, bus_struct_reset, peripheral_aresetn, peripheral_reset} !== 4'b0101) begin
      errors++;
      $display("FAIL async_outputs: got %b expected 0101",
               {interconnect_aresetn, bus_struct_reset, peripheral_aresetn, peripheral_reset});
    end
    for (int i = 0; i < 3; i++) tick();
    test_powerup("rerun");
  endtask

`ifdef AXI_RST_SEQ_STATUS_EN
  task automatic test_status();
    mb_debug_sys_rst = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      rec(e);
      if (e == 1) mb_debug_sys_rst = 1'b0;
    end
    checks++;
    if (rst_cause !== 4'b0100 || rst_count !== 8'd1) begin
      errors++;
      $display("FAIL status_dbg: got cause=%b count=%0d expected 0100/1", rst_cause, rst_count);
    end
    dcm_locked = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      rec(e);
      if (e == 1) dcm_locked = 1'b1;
    end
    checks++;
    if (rst_cause !== 4'b1000 || rst_count !== 8'd2) begin
      errors++;
      $display("FAIL status_lock: got cause=%b count=%0d expected 1000/2", rst_cause, rst_count);
    end
    for (int p = 0; p < 300; p++) begin
      ext_reset_in = 1'b1;
      tick();
      ext_reset_in = 1'b0;
      for (int i = 0; i < 5; i++) tick();
    end
    checks++;
    if (rst_cause !== 4'b0001 || rst_count !== 8'hFF) begin
      errors++;
      $display("FAIL status_sat: got cause=%b count=%0d expected 0001/255", rst_cause, rst_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup("powerup");
    test_ext_pulse();
    test_hold_abort();
    test_relic_lockloss();
    test_async_mid_run();
`ifdef AXI_RST_SEQ_STATUS_EN
    test_status();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
